priv_intr_arbiter: RTL and testbench

Parametrised interrupt pending/arbitration unit for the privilege block. It is the next generation of the fixed nine-source (U/S/M × timer/soft/ext) interrupt path, generalised to NUM_INT sources with per-source delegation and optional edge-latched sources. It registers pending state and selects the winning eligible interrupt under current privilege, global enables and delegation. It then holds a stable request to pipe control until the pipeline can take it. It sits between the interrupt sources / CSR file and the int/ex handler and pipe control.

---
 rtl/priv_intr_arbiter_if.sv | 21 ++
 rtl/priv_intr_arbiter.sv | 84 ++++++++
 tb/tb_priv_intr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/priv_intr_arbiter_if.sv
// priv_intr_arbiter_if: interrupt sources, CSR views and the pipe-control request bundle
interface priv_intr_arbiter_if #(
  parameter int NUM_INT = 16,
  parameter int CAUSE_W = $clog2(NUM_INT)
);
  logic [NUM_INT-1:0] int_src, int_clear, int_en, int_deleg, pending;
  logic               mie_global, sie_global, pipe_clear, ex_mem_stall;
  logic [1:0]         curr_priv;
  logic               intr, intr_to_s, intr_taken;
  logic [CAUSE_W-1:0] intr_cause;
  modport master (
    input  int_src, int_clear, int_en, int_deleg, mie_global, sie_global, curr_priv,
           pipe_clear, ex_mem_stall,
    output pending, intr, intr_to_s, intr_cause, intr_taken
  );
  modport slave (
    output int_src, int_clear, int_en, int_deleg, mie_global, sie_global, curr_priv,
           pipe_clear, ex_mem_stall,
    input  pending, intr, intr_to_s, intr_cause, intr_taken
  );
endinterface

// File: rtl/priv_intr_arbiter.sv
// priv_intr_arbiter: pending/arbitration of NUM_INT interrupts with M/S delegation.
// Define INT_EDGE_DETECT_EN to make EDGE_MASK sources edge-latched (cleared by int_clear or take).
module priv_intr_arbiter #(
  parameter int                 NUM_INT   = 16,
  parameter int                 CAUSE_W   = $clog2(NUM_INT),
  parameter logic [NUM_INT-1:0] EDGE_MASK = '0
) (
  input logic CLK,
  input logic nRST,
  priv_intr_arbiter_if.master b
);
  typedef enum logic [1:0] {IDLE, WAIT, TAKE} state_t;
  state_t             state;
  logic               m_ok, s_ok;
  logic [NUM_INT-1:0] elig_m, elig_s, elig;
  logic [CAUSE_W-1:0] win_m, win_s;
  assign m_ok   = b.curr_priv != 2'd3 || b.mie_global;
  assign s_ok   = b.curr_priv == 2'd0 || (b.curr_priv == 2'd1 && b.sie_global);
  assign elig_m = b.pending & b.int_en & ~b.int_deleg & {NUM_INT{m_ok}};
  assign elig_s = b.pending & b.int_en & b.int_deleg & {NUM_INT{s_ok}};
  assign elig   = elig_m | elig_s;
  // Ascending scan: the last hit is the highest index in each target group
  always_comb begin
    win_m = '0;
    win_s = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      win_m = elig_m[i] ? CAUSE_W'(i) : win_m;
      win_s = elig_s[i] ? CAUSE_W'(i) : win_s;
    end
  end
`ifdef INT_EDGE_DETECT_EN
  logic [NUM_INT-1:0] src_q, take_clr;
  assign take_clr = state == TAKE ? NUM_INT'(1) << b.intr_cause : '0;
  // Set beats a simultaneous clear on edge sources
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      src_q     <= '0;
      b.pending <= '0;
    end else begin
      src_q     <= b.int_src;
      b.pending <= (EDGE_MASK & ((b.int_src & ~src_q) | (b.pending & ~(b.int_clear | take_clr))))
                 | (~EDGE_MASK & b.int_src);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{b.int_clear, EDGE_MASK};
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) b.pending <= '0;
    else       b.pending <= b.int_src;
  end
`endif
  // Withdraw is tested before acceptance so a vanishing source is never taken
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      b.intr       <= 1'b0;
      b.intr_to_s  <= 1'b0;
      b.intr_cause <= '0;
      b.intr_taken <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|elig) begin
          state        <= WAIT;
          b.intr       <= 1'b1;
          b.intr_to_s  <= ~|elig_m;
          b.intr_cause <= |elig_m ? win_m : win_s;
        end
        WAIT: if (!elig[b.intr_cause]) begin
          state  <= IDLE;
          b.intr <= 1'b0;
        end else if (b.pipe_clear && !b.ex_mem_stall) begin
          state        <= TAKE;
          b.intr       <= 1'b0;
          b.intr_taken <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          b.intr_taken <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_priv_intr_arbiter.sv
// tb_priv_intr_arbiter: directed scenarios plus randomized run against a spec-level model
module tb_priv_intr_arbiter;
  localparam int          N  = 16;
  localparam logic [N-1:0] EM = 16'h0200;
  logic clk = 1'b0, nrst = 1'b0;
  int n_checks = 0, n_fail = 0;
  priv_intr_arbiter_if #(.NUM_INT(N)) bus();
  priv_intr_arbiter #(.NUM_INT(N), .EDGE_MASK(EM)) dut (.CLK(clk), .nRST(nrst), .b(bus));
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic zero_inputs();
    bus.int_src = '0; bus.int_clear = '0; bus.int_en = '0; bus.int_deleg = '0;
    bus.mie_global = 1'b0; bus.sie_global = 1'b0; bus.curr_priv = 2'd0;
    bus.pipe_clear = 1'b0; bus.ex_mem_stall = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    nrst = 1'b0;
    step(2);
    nrst = 1'b1;
    step(1);
  endtask

  function automatic logic elig1(input int i, input logic [N-1:0] p, en, dg,
                                 input logic [1:0] pv, input logic mie, sie);
    if (!(p[i] && en[i])) return 1'b0;
    return dg[i] ? (pv == 2'd0 || (pv == 2'd1 && sie)) : (pv != 2'd3 || mie);
  endfunction

  // M targets outrank all S targets; highest index within a group
  function automatic int pick(input logic [N-1:0] p, en, dg, input logic [1:0] pv,
                              input logic mie, sie, output logic ts);
    for (int i = N - 1; i >= 0; i--)
      if (!dg[i] && elig1(i, p, en, dg, pv, mie, sie)) begin ts = 1'b0; return i; end
    for (int i = N - 1; i >= 0; i--)
      if (dg[i] && elig1(i, p, en, dg, pv, mie, sie)) begin ts = 1'b1; return i; end
    ts = 1'b0;
    return -1;
  endfunction

  task automatic test_reset();
    zero_inputs();
    bus.int_src = 16'hffff;
    nrst = 1'b0;
    #2;
    n_checks++;
    if ({bus.pending, bus.intr, bus.intr_to_s, bus.intr_cause, bus.intr_taken} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pend=%h intr=%b to_s=%b cause=%0d taken=%b want all 0",
               bus.pending, bus.intr, bus.intr_to_s, bus.intr_cause, bus.intr_taken);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    bus.int_en = 16'h0880; bus.int_src = 16'h0880;
    step();
    n_checks++;
    if (bus.intr !== 1'b0 || bus.pending !== 16'h0880) begin
      n_fail++; $display("FAIL basic_lat1: got intr=%b pend=%h want 0/0880", bus.intr, bus.pending);
    end
    step();
    n_checks++;
    if (bus.intr !== 1'b1 || bus.intr_cause !== 4'd11 || bus.intr_to_s !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_req: got intr=%b cause=%0d to_s=%b want 1/11/0", bus.intr, bus.intr_cause, bus.intr_to_s);
    end
    bus.pipe_clear = 1'b1;
    step();
    n_checks++;
    if (bus.intr_taken !== 1'b1 || bus.intr !== 1'b0) begin
      n_fail++; $display("FAIL basic_take: got taken=%b intr=%b want 1/0", bus.intr_taken, bus.intr);
    end
    step();
    n_checks++;
    if (bus.intr_taken !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: got taken=%b want 0", bus.intr_taken);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.curr_priv = 2'd1; bus.sie_global = 1'b1; bus.int_deleg = 16'h0020;
    bus.int_en = 16'h0028; bus.int_src = 16'h0028;
    step(2);
    n_checks++;
    if (bus.intr !== 1'b1 || bus.intr_cause !== 4'd3 || bus.intr_to_s !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_m: got intr=%b cause=%0d to_s=%b want 1/3/0", bus.intr, bus.intr_cause, bus.intr_to_s);
    end
    bus.pipe_clear = 1'b1;
    step();
    n_checks++;
    if (bus.intr_taken !== 1'b1) begin
      n_fail++; $display("FAIL prio_take: got taken=%b want 1", bus.intr_taken);
    end
    bus.int_src = 16'h0020;
    step();
    n_checks++;
    if (bus.intr !== 1'b0) begin
      n_fail++; $display("FAIL prio_gap: got intr=%b want 0", bus.intr);
    end
    step();
    n_checks++;
    if (bus.intr !== 1'b1 || bus.intr_cause !== 4'd5 || bus.intr_to_s !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_s: got intr=%b cause=%0d to_s=%b want 1/5/1", bus.intr, bus.intr_cause, bus.intr_to_s);
    end
  endtask

  task automatic test_mie();
    do_reset();
    bus.curr_priv = 2'd3; bus.int_en = 16'h0080; bus.int_src = 16'h0080;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus.intr !== 1'b0) begin
        n_fail++; $display("FAIL mie_masked: cycle %0d got intr=%b want 0", i, bus.intr);
      end
    end
    bus.mie_global = 1'b1;
    step();
    n_checks++;
    if (bus.intr !== 1'b1 || bus.intr_cause !== 4'd7) begin
      n_fail++; $display("FAIL mie_on: got intr=%b cause=%0d want 1/7", bus.intr, bus.intr_cause);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.int_en = 16'h0004; bus.int_src = 16'h0004; bus.pipe_clear = 1'b1; bus.ex_mem_stall = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus.intr !== 1'b1 || bus.intr_cause !== 4'd2 || bus.intr_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got intr=%b cause=%0d taken=%b want 1/2/0",
                 i, bus.intr, bus.intr_cause, bus.intr_taken);
      end
    end
    bus.ex_mem_stall = 1'b0;
    step();
    n_checks++;
    if (bus.intr_taken !== 1'b1 || bus.intr !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got taken=%b intr=%b want 1/0", bus.intr_taken, bus.intr);
    end
    do_reset();
    bus.int_en = 16'h0004; bus.int_src = 16'h0004; bus.pipe_clear = 1'b1; bus.ex_mem_stall = 1'b1;
    step(2);
    n_checks++;
    if (bus.intr !== 1'b1) begin
      n_fail++; $display("FAIL withdraw_req: got intr=%b want 1", bus.intr);
    end
    bus.ex_mem_stall = 1'b0; bus.int_en = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.intr !== 1'b0 || bus.intr_taken !== 1'b0) begin
        n_fail++; $display("FAIL withdraw: cycle %0d got intr=%b taken=%b want 0/0", i, bus.intr, bus.intr_taken);
      end
    end
  endtask

`ifdef INT_EDGE_DETECT_EN
  task automatic test_edge();
    do_reset();
    bus.int_en = 16'h0200; bus.int_src = 16'h0200;
    step();
    bus.int_src = '0;
    step(3);
    n_checks++;
    if (bus.pending[9] !== 1'b1 || bus.intr !== 1'b1 || bus.intr_cause !== 4'd9) begin
      n_fail++;
      $display("FAIL edge_latch: got pend9=%b intr=%b cause=%0d want 1/1/9", bus.pending[9], bus.intr, bus.intr_cause);
    end
    bus.pipe_clear = 1'b1;
    step();
    bus.pipe_clear = 1'b0;
    step();
    n_checks++;
    if (bus.pending[9] !== 1'b0) begin
      n_fail++; $display("FAIL edge_take_clr: got pend9=%b want 0", bus.pending[9]);
    end
    bus.int_src = 16'h0208; bus.int_clear = 16'h0208;
    step();
    n_checks++;
    if (bus.pending[9] !== 1'b1 || bus.pending[3] !== 1'b1) begin
      n_fail++; $display("FAIL edge_set_wins: got pend9=%b pend3=%b want 1/1", bus.pending[9], bus.pending[3]);
    end
    bus.int_src = '0; bus.int_clear = 16'h0200;
    step();
    n_checks++;
    if (bus.pending[9] !== 1'b0) begin
      n_fail++; $display("FAIL edge_sw_clr: got pend9=%b want 0", bus.pending[9]);
    end
  endtask
`endif

  task automatic test_reset_wait();
    do_reset();
    bus.int_en = 16'h0010; bus.int_src = 16'h0010;
    step(2);
    n_checks++;
    if (bus.intr !== 1'b1) begin
      n_fail++; $display("FAIL rstw_req: got intr=%b want 1", bus.intr);
    end
    #2 nrst = 1'b0;
    #1;
    n_checks++;
    if ({bus.pending, bus.intr, bus.intr_to_s, bus.intr_cause, bus.intr_taken} !== '0) begin
      n_fail++;
      $display("FAIL rstw_async: got pend=%h intr=%b cause=%0d taken=%b want all 0",
               bus.pending, bus.intr, bus.intr_cause, bus.intr_taken);
    end
    step(2);
    bus.int_src = '0; nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus.intr !== 1'b0 || bus.intr_taken !== 1'b0) begin
        n_fail++; $display("FAIL rstw_quiet: cycle %0d got intr=%b taken=%b want 0/0", i, bus.intr, bus.intr_taken);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] mp, mq, np, tk;
    int ph, nph, mc, w;
    logic mts, t;
    do_reset();
    mp = '0; mq = '0; ph = 0; mc = 0; mts = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0) bus.int_src = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.int_en = N'($urandom); bus.int_deleg = N'($urandom);
        bus.curr_priv = 2'($urandom_range(0, 3));
        bus.mie_global = 1'($urandom); bus.sie_global = 1'($urandom);
      end
      bus.pipe_clear = 1'($urandom);
      bus.ex_mem_stall = $urandom_range(0, 3) == 0;
      bus.int_clear = N'($urandom) & N'($urandom);
      tk = ph == 2 ? N'(1) << mc : '0;
`ifdef INT_EDGE_DETECT_EN
      np = (EM & ((bus.int_src & ~mq) | (mp & ~(bus.int_clear | tk)))) | (~EM & bus.int_src);
`else
      np = bus.int_src;
`endif
      nph = ph;
      if (ph == 0) begin
        w = pick(mp, bus.int_en, bus.int_deleg, bus.curr_priv, bus.mie_global, bus.sie_global, t);
        if (w >= 0) begin nph = 1; mc = w; mts = t; end
      end else if (ph == 1) begin
        if (!elig1(mc, mp, bus.int_en, bus.int_deleg, bus.curr_priv, bus.mie_global, bus.sie_global)) nph = 0;
        else if (bus.pipe_clear && !bus.ex_mem_stall) nph = 2;
      end else nph = 0;
      mq = bus.int_src;
      step();
      mp = np; ph = nph;
      n_checks++;
      if (bus.pending !== mp || bus.intr !== (ph == 1) || bus.intr_taken !== (ph == 2)) begin
        n_fail++;
        $display("FAIL rand_state: cycle %0d got pend=%h intr=%b taken=%b want %h/%b/%b",
                 c, bus.pending, bus.intr, bus.intr_taken, mp, ph == 1, ph == 2);
      end
      if (ph != 0) begin
        n_checks++;
        if (bus.intr_cause !== 4'(mc) || bus.intr_to_s !== mts) begin
          n_fail++;
          $display("FAIL rand_cause: cycle %0d got cause=%0d to_s=%b want %0d/%b",
                   c, bus.intr_cause, bus.intr_to_s, mc, mts);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mie();
    test_stall();
`ifdef INT_EDGE_DETECT_EN
    test_edge();
`endif
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
